// File: rtl/reg_share_arbiter_amisha_pkg.sv
// Shared types and defaults for the round-robin register-share arbiter.
package reg_arb_pkg_amisha;

   localparam int N_REQ_DEF  = 4;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      WRITE = 2'b01,
      ACK   = 2'b10
   } state_t;

endpackage

// File: rtl/reg_share_arbiter_amisha_if.sv
// Requester/register-side bundle for the register-share arbiter.
interface reg_share_arbiter_amisha_if
   import reg_arb_pkg_amisha::*;
#(
   parameter int N_REQ  = N_REQ_DEF,
   parameter int DATA_W = DATA_W_DEF
) ();

   logic [N_REQ-1:0]         req_amisha;
   logic [N_REQ*DATA_W-1:0]  data_amisha;
   logic                     en_amisha;
   logic [DATA_W-1:0]        d_amisha;
   logic [N_REQ-1:0]         ack_amisha;
   logic                     busy_amisha;
   logic [$clog2(N_REQ)-1:0] last_grant_amisha;

   modport master (
      output req_amisha, data_amisha,
      input  en_amisha, d_amisha, ack_amisha, busy_amisha, last_grant_amisha
   );

   modport slave (
      input  req_amisha, data_amisha,
      output en_amisha, d_amisha, ack_amisha, busy_amisha, last_grant_amisha
   );

endinterface

// File: rtl/reg_share_arbiter_amisha_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, with wrap.
module rr_pick_amisha
   import reg_arb_pkg_amisha::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic             o_valid,
   output logic [IDX_W-1:0] o_idx
);

   localparam logic [IDX_W:0] N_L = (IDX_W+1)'(N_REQ);

   logic [IDX_W:0]   w_sum  [N_REQ];
   logic [IDX_W-1:0] w_cand [N_REQ];
   logic             w_hit  [N_REQ];

   // Candidate gi is the requester gi positions after the pointer.
   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_cand
         assign w_sum[gi]  = {1'b0, i_ptr} + (IDX_W+1)'(gi);
         assign w_cand[gi] = (w_sum[gi] >= N_L) ? IDX_W'(w_sum[gi] - N_L)
                                                : IDX_W'(w_sum[gi]);
         assign w_hit[gi]  = i_req[w_cand[gi]];
      end
   endgenerate

   always_comb begin
      o_valid = 1'b0;
      o_idx   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (w_hit[k]) begin
            o_valid = 1'b1;
            o_idx   = w_cand[k];
         end
      end
   end

endmodule

// File: rtl/reg_share_arbiter_amisha.sv
// Round-robin arbiter that time-shares one enabled D-register among N_REQ requesters:
// grant in IDLE, one-cycle write enable, then a one-cycle one-hot acknowledge.
module reg_share_arbiter_amisha
   import reg_arb_pkg_amisha::*;
#(
   parameter int N_REQ  = N_REQ_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                        clk_amisha,
   input  logic                        reset_amisha,
   reg_share_arbiter_amisha_if.slave   bus
);

   localparam int IDX_W = $clog2(N_REQ);

   state_t             r_state;
   state_t             w_state_next;
   logic [IDX_W-1:0]   r_ptr;
   logic [IDX_W-1:0]   r_last_grant;
   logic               r_en;
   logic [DATA_W-1:0]  r_d;
   logic [N_REQ-1:0]   r_ack;

   logic               w_pick_valid;
   logic [IDX_W-1:0]   w_pick_idx;
   logic [DATA_W-1:0]  w_data_arr [N_REQ];
   logic [N_REQ-1:0]   w_ack_onehot;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_lane
         assign w_data_arr[gi]   = bus.data_amisha[gi*DATA_W +: DATA_W];
         assign w_ack_onehot[gi] = (r_last_grant == IDX_W'(gi));
      end
   endgenerate

   rr_pick_amisha #(.N_REQ(N_REQ)) u_pick (
      .i_req   (bus.req_amisha),
      .i_ptr   (r_ptr),
      .o_valid (w_pick_valid),
      .o_idx   (w_pick_idx)
   );

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_pick_valid) w_state_next = WRITE;
         WRITE:   w_state_next = ACK;
         ACK:     w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Requests are only sampled in IDLE; the granted index is held for the ack.
   always_ff @(posedge clk_amisha) begin
      if (reset_amisha) begin
         r_state      <= IDLE;
         r_ptr        <= '0;
         r_last_grant <= '0;
         r_en         <= 1'b0;
         r_d          <= '0;
         r_ack        <= '0;
      end else begin
         r_state <= w_state_next;
         r_en    <= (w_state_next == WRITE);
         r_ack   <= (r_state == WRITE) ? w_ack_onehot : '0;
         if (r_state == IDLE && w_pick_valid) begin
            r_d          <= w_data_arr[w_pick_idx];
            r_last_grant <= w_pick_idx;
         end
         if (r_state == ACK) begin
            r_ptr <= (r_last_grant == IDX_W'(N_REQ - 1)) ? '0
                                                         : r_last_grant + IDX_W'(1);
         end
      end
   end

   assign bus.en_amisha         = r_en;
   assign bus.d_amisha          = r_d;
   assign bus.ack_amisha        = r_ack;
   assign bus.busy_amisha       = (r_state != IDLE);
   assign bus.last_grant_amisha = r_last_grant;

endmodule

// File: tb/tb_reg_share_arbiter_amisha.sv
// Directed bench for reg_share_arbiter_amisha with an expected-write scoreboard.
module tb_reg_share_arbiter_amisha;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   cyc0  = 0;

   typedef struct {
      int         idx;
      logic [7:0] data;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   reg_share_arbiter_amisha_if #(.N_REQ(4), .DATA_W(8)) bus_if ();

   reg_share_arbiter_amisha #(.N_REQ(4), .DATA_W(8)) dut (
      .clk_amisha   (clk),
      .reset_amisha (rst),
      .bus          (bus_if)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   task automatic set_data(input int i, input logic [7:0] v);
      bus_if.data_amisha[i*8 +: 8] = v;
   endtask

   // Wait for the next write, compare against the scoreboard head, then check its ack.
   task automatic serve(input string tag, input int exp_rel);
      exp_t e;
      int   waited;
      logic [3:0] oh;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      waited = 0;
      while (bus_if.en_amisha !== 1'b1 && waited < 12) begin
         step();
         waited++;
      end
      check({tag, "_en"}, 32'(bus_if.en_amisha), 32'd1);
      check({tag, "_d"}, 32'(bus_if.d_amisha), 32'(e.data));
      check({tag, "_grant"}, 32'(bus_if.last_grant_amisha), 32'(e.idx));
      step();
      oh = 4'b0001 << e.idx;
      check({tag, "_ack"}, 32'(bus_if.ack_amisha), 32'(oh));
      check({tag, "_en_off"}, 32'(bus_if.en_amisha), 32'd0);
      if (exp_rel >= 0) check({tag, "_ack_cyc"}, 32'(cyc - cyc0), 32'(exp_rel));
      $display("txn %s: idx=%0d d=%0h ack=%b at rel cycle %0d", tag, e.idx,
               bus_if.d_amisha, bus_if.ack_amisha, cyc - cyc0);
      bus_if.req_amisha[e.idx] = 1'b0;
   endtask

   initial begin
      // Reset with random activity on the inputs.
      bus_if.req_amisha  = 4'($urandom);
      bus_if.data_amisha = 32'($urandom);
      step();
      bus_if.req_amisha  = 4'($urandom);
      bus_if.data_amisha = 32'($urandom);
      step();
      check("rst_en", 32'(bus_if.en_amisha), 32'd0);
      check("rst_ack", 32'(bus_if.ack_amisha), 32'd0);
      check("rst_d", 32'(bus_if.d_amisha), 32'd0);
      check("rst_busy", 32'(bus_if.busy_amisha), 32'd0);
      check("rst_grant", 32'(bus_if.last_grant_amisha), 32'd0);
      bus_if.req_amisha  = 4'b0000;
      bus_if.data_amisha = '0;
      rst = 1'b0;
      step();

      // Single request from requester 1.
      set_data(1, 8'hA5);
      bus_if.req_amisha = 4'b0010;
      sb.push_back('{1, 8'hA5});
      cyc0 = cyc;
      serve("single", 2);
      step();
      check("single_busy_c3", 32'(bus_if.busy_amisha), 32'd0);
      check("single_ack_c3", 32'(bus_if.ack_amisha), 32'd0);
      step();
      check("single_d_hold", 32'(bus_if.d_amisha), 32'hA5);

      // Fresh pointer, all four requesting.
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_data(i, 8'(8'h10 + i));
         sb.push_back('{i, 8'(8'h10 + i)});
      end
      bus_if.req_amisha = 4'b1111;
      cyc0 = cyc;
      serve("all0", 2);
      serve("all1", 5);
      serve("all2", 8);
      serve("all3", 11);

      // Serve requester 2 so the pointer sits at 3, then check wrap.
      set_data(2, 8'h22);
      bus_if.req_amisha = 4'b0100;
      sb.push_back('{2, 8'h22});
      serve("pre_wrap", -1);
      step();
      set_data(0, 8'h40);
      set_data(2, 8'h42);
      bus_if.req_amisha = 4'b0101;
      sb.push_back('{0, 8'h40});
      sb.push_back('{2, 8'h42});
      cyc0 = cyc;
      serve("wrap0", 2);
      serve("wrap2", 5);
      step();

      // Reset during WRITE drops the transaction.
      set_data(2, 8'h3C);
      bus_if.req_amisha = 4'b0100;
      step();
      check("rw_en_write", 32'(bus_if.en_amisha), 32'd1);
      rst = 1'b1;
      step();
      check("rw_en", 32'(bus_if.en_amisha), 32'd0);
      check("rw_ack", 32'(bus_if.ack_amisha), 32'd0);
      check("rw_busy", 32'(bus_if.busy_amisha), 32'd0);
      check("rw_d", 32'(bus_if.d_amisha), 32'd0);
      rst = 1'b0;
      // Requester 3 also asks: a reset pointer must still favour requester 2.
      set_data(3, 8'h33);
      bus_if.req_amisha = 4'b1100;
      sb.push_back('{2, 8'h3C});
      sb.push_back('{3, 8'h33});
      cyc0 = cyc;
      serve("rw_2", 2);
      serve("rw_3", 5);
      step();

      // Request withdrawn during WRITE still completes.
      set_data(0, 8'h5A);
      bus_if.req_amisha = 4'b0001;
      step();
      check("wd_en", 32'(bus_if.en_amisha), 32'd1);
      check("wd_d", 32'(bus_if.d_amisha), 32'h5A);
      bus_if.req_amisha = 4'b0000;
      step();
      check("wd_ack", 32'(bus_if.ack_amisha), 32'b0001);
      $display("txn withdraw: ack=%b", bus_if.ack_amisha);
      for (int i = 0; i < 4; i++) begin
         step();
         check("wd_idle_en", 32'(bus_if.en_amisha), 32'd0);
         check("wd_idle_busy", 32'(bus_if.busy_amisha), 32'd0);
      end
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reg_share_arbiter_amisha.md
# reg_share_arbiter_amisha

Round-robin controller that shares one enabled D-register bank among `N_REQ` requesters. Each requester holds a request with its data. The arbiter picks one requester, drives the register's enable and data for exactly one cycle, then returns a one-cycle acknowledge. It sits between the requesting logic and the enabled D flip-flop register, and is the only driver of that register's `en`/`d` inputs.

## Interface
- `N_REQ`, 4: number of requesters (≥2).
- `DATA_W`, 8: width of the shared register.
- `clk_amisha`  in  1  single clock, rising edge.
- `reset_amisha`  in  1  synchronous, active-high reset.
- `req_amisha`  in  N_REQ  request bit per requester; held high until acked.
- `data_amisha`  in  N_REQ*DATA_W  packed write data; requester i owns bits [i*DATA_W +: DATA_W].
- `en_amisha`  out  1  write enable to the register; registered.
- `d_amisha`  out  DATA_W  write data to the register; registered.
- `ack_amisha`  out  N_REQ  one-hot, one-cycle completion pulse; registered.
- `busy_amisha`  out  1  high when state ≠ IDLE.
- `last_grant_amisha`  out  $clog2(N_REQ)  index of the most recently granted requester.

## Operation
- FSM states:
  - IDLE: if `req_amisha` ≠ 0, pick a winner, capture its data into `d_amisha` and its index into `last_grant_amisha`, then go to WRITE. Otherwise stay in IDLE.
  - WRITE: `en_amisha`=1 for this one cycle; go to ACK.
  - ACK: `ack_amisha`[idx]=1 for this one cycle; set `ptr` ← (idx+1) mod N_REQ; go to IDLE.
- Round-robin: search starts at `ptr` and increments with wrap; the first set bit wins.
- `d_amisha` is loaded only at grant, and holds its value outside writes.
- Withdrawn request: if `req_amisha`[idx] drops during WRITE or ACK, the write still completes and the ack is still issued.
- Requester rule: drop `req` at the same edge that samples `ack` high. A request left high is treated as a new request, at lowest priority because `ptr` has advanced.
- Only requests sampled in IDLE are considered. Requests arriving in WRITE or ACK wait.
- Reset (any state, including mid-write):
  - state → IDLE, `ptr`=0.
  - `en_amisha`=0, `ack_amisha`=0, `d_amisha`=0, `last_grant_amisha`=0, `busy_amisha`=0.
  - The in-flight transaction is dropped with no ack; a still-high request is re-arbitrated after reset releases.

## Timing
- Request seen in IDLE at cycle 0 → `en_amisha`=1 in cycle 1 → `ack_amisha` in cycle 2 → IDLE in cycle 3.
- Maximum throughput: one write per 3 cycles.
- Register captures `d_amisha` at the end of cycle 1.
- Worst-case wait for a continuously requesting port: (N_REQ−1)·3 cycles after its first IDLE sample.
- `busy_amisha` is high in cycles 1–2 of each transaction.
- All outputs change only on the rising edge of `clk_amisha`.

## Structure
- Package `reg_arb_pkg_amisha` holds:
  - state typedef: IDLE=2'b00, WRITE=2'b01, ACK=2'b10; 2'b11 recovers to IDLE.
  - default `N_REQ` and `DATA_W` constants.
- Sub-module `rr_pick_amisha` (combinational): inputs `req` and `ptr`; outputs `valid` and winner index.
- Top level holds the FSM, `ptr`, the data mux and the output registers.

## Test plan
Conditions for all scenarios: N_REQ=4, DATA_W=8.
- Reset held 2 cycles with random `req`/`data` → `en`=0, `ack`=0000, `d`=0x00, `busy`=0, `last_grant`=0.
- `req`=0010, `data[1]`=0xA5 at cycle 0 → cycle 1: `en`=1, `d`=0xA5; cycle 2: `ack`=0010, `en`=0; cycle 3: `busy`=0. `d` stays 0xA5 afterwards.
- `req`=1111, each dropped on its ack, `data[i]`=0x10+i → writes 0x10, 0x11, 0x12, 0x13 in order, with acks at cycles 2, 5, 8, 11.
- Pointer wrap: after serving requester 2 (`ptr`=3), `req`=0101 → requester 0 acked first, then requester 2.
- `req`=0100, `data[2]`=0x3C; reset pulsed during WRITE → next cycle `en`=0, no ack, `ptr`=0. After release: 0x3C written and `ack`=0100.
- `req`=0001 dropped during WRITE → ack=0001 still issued in cycle 2; arbiter then returns to IDLE and stays idle.
